pulse_generator: RTL and testbench

//  Drive-side counterpart of the edge detector: turns a one-cycle trigger strobe into a clean

---
 rtl/pulse_generator_pkg.sv | 20 ++
 rtl/pulse_generator_counter.sv | 46 ++++
 rtl/pulse_generator.sv | 162 ++++++++++++++++
 tb/tb_pulse_generator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_generator_pkg.sv
// -----------------------------------------------------------------------------
// pulse_generator_pkg
//   Shared definitions for the pulse generator slice: FSM state encodings and
//   the two polarity constants used by the control-pin drivers.
// -----------------------------------------------------------------------------
package pulse_generator_pkg;

  // Encodings are fixed so the state can be probed against existing
  // sequencer documentation.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // pos_neg values: POL_HIGH = idle low / active high, POL_LOW = idle high / active low.
  localparam logic POL_HIGH = 1'b1;
  localparam logic POL_LOW  = 1'b0;

endpackage

// File: rtl/pulse_generator_counter.sv
// -----------------------------------------------------------------------------
// load_down_counter
//   Loadable down-counter that saturates at zero (never wraps). The loaded
//   value is held while en is low.
//   Ports:
//     iClk    in   clock
//     iRst_n  in   synchronous active-low reset (count -> 0)
//     clr     in   synchronous clear (count -> 0)
//     load    in   load val (has priority over en)
//     val     in   W-bit load value
//     en      in   decrement enable
//     cnt     out  W-bit current count
//     last    out  count equals 1 (final cycle of the interval)
// -----------------------------------------------------------------------------
module load_down_counter #(
  parameter int W = 16
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;

  // NOTE: reset is synchronous, so it is just the highest-priority branch of
  // the clocked block; state updates use non-blocking (<=) so every flop sees
  // the pre-edge values of the others.
  always_ff @(posedge iClk) begin
    if (!iRst_n || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_generator.sv
// -----------------------------------------------------------------------------
// pulse_generator
//   Turns a one-cycle trigger strobe into a single clean pulse on a control
//   pin, after a programmable delay, with programmable width and polarity.
//   Ports:
//     iClk      in   system clock
//     iRst_n    in   synchronous active-low reset
//     iClear    in   synchronous abort (same effect as reset)
//     iTrigger  in   one-cycle start strobe
//     pos_neg   in   polarity: 1 = idle low/active high, 0 = idle high/active low
//     iDelay    in   cycles from trigger to assertion (sampled with trigger)
//     iWidth    in   active cycles, 0 treated as 1 (sampled with trigger)
//     oPulse    out  registered pulse
//     oBusy     out  delay or active phase in progress
//     oDone     out  one-cycle strobe as oPulse returns to idle
//     oOverrun  out  one-cycle strobe: trigger dropped while busy (RETRIG=0)
//
//   The FSM state is one cycle ahead of the outputs: every output flop is
//   computed from the registered state, so no input reaches an output
//   combinationally and a trigger on edge T asserts oPulse on edge T+1+D.
// -----------------------------------------------------------------------------
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int DLY_W  = 16,
  parameter int PW_W   = 16,
  parameter bit RETRIG = 1'b0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClear,
  input  logic             iTrigger,
  input  logic             pos_neg,
  input  logic [DLY_W-1:0] iDelay,
  input  logic [PW_W-1:0]  iWidth,
  output logic             oPulse,
  output logic             oBusy,
  output logic             oDone,
  output logic             oOverrun
);

  state_e state_q;
  logic   pol_q;        // polarity latched at the trigger
  logic   done_ev_q;    // ACTIVE -> IDLE happened this edge
  logic   ovr_ev_q;     // trigger dropped this edge
  logic   pulse_q;
  logic   busy_q;
  logic   done_q;
  logic   ovr_q;

  logic             rst_all;
  logic             busy;
  logic             start;
  logic             retrig;
  logic             dly_zero;
  logic [PW_W-1:0]  width_ld;
  logic             dly_load;
  logic             wid_load;
  logic [DLY_W-1:0] dly_cnt;
  logic [PW_W-1:0]  wid_cnt;
  logic             dly_last;
  logic             wid_last;
  logic             dly_end;
  logic             wid_end;

  assign rst_all  = !iRst_n || iClear;
  assign busy     = (state_q != ST_IDLE);
  assign start    = iTrigger && (state_q == ST_IDLE);
  assign retrig   = iTrigger && busy && RETRIG;
  assign dly_zero = (iDelay == '0);
  assign width_ld = (iWidth == '0) ? PW_W'(1) : iWidth;

  // Width is only loaded at a start or an ACTIVE retrigger; a DELAY
  // retrigger restarts the delay but keeps the width captured at the start.
  assign dly_load = start || (retrig && (state_q == ST_DELAY));
  assign wid_load = start || (retrig && (state_q == ST_ACTIVE));

  // A zero count can only arise from a zero delay load, which the FSM
  // bypasses; treating it as "end" guarantees the FSM can never stall.
  assign dly_end = dly_last || (dly_cnt == '0);
  assign wid_end = wid_last || (wid_cnt == '0);

  load_down_counter #(.W(DLY_W)) u_dly_cnt (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .clr    (iClear),
    .load   (dly_load),
    .val    (iDelay),
    .en     (state_q == ST_DELAY),
    .cnt    (dly_cnt),
    .last   (dly_last)
  );

  load_down_counter #(.W(PW_W)) u_wid_cnt (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .clr    (iClear),
    .load   (wid_load),
    .val    (width_ld),
    .en     (state_q == ST_ACTIVE),
    .cnt    (wid_cnt),
    .last   (wid_last)
  );

  always_ff @(posedge iClk) begin
    if (rst_all) begin
      state_q   <= ST_IDLE;
      pol_q     <= POL_HIGH;
      done_ev_q <= 1'b0;
      ovr_ev_q  <= 1'b0;
      pulse_q   <= ~pos_neg;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      done_ev_q <= 1'b0;
      ovr_ev_q  <= iTrigger && busy && !RETRIG;

      case (state_q)
        ST_IDLE: begin
          if (iTrigger) begin
            pol_q   <= pos_neg;
            state_q <= dly_zero ? ST_ACTIVE : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (retrig) begin
            if (dly_zero) state_q <= ST_ACTIVE;
          end else if (dly_end) begin
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A retrigger reloads the width counter and holds ACTIVE, so the
          // output never drops between the old and the extended pulse.
          if (!retrig && wid_end) begin
            state_q   <= ST_IDLE;
            done_ev_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Output stage: one register behind the FSM. In IDLE the live polarity
      // is followed; otherwise the polarity latched at the trigger is used.
      case (state_q)
        ST_ACTIVE: pulse_q <= pol_q;
        ST_DELAY:  pulse_q <= ~pol_q;
        default:   pulse_q <= ~pos_neg;
      endcase
      busy_q <= busy;
      done_q <= done_ev_q;
      ovr_q  <= ovr_ev_q;
    end
  end

  assign oPulse   = pulse_q;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oOverrun = ovr_q;

endmodule

// File: tb/tb_pulse_generator.sv
// -----------------------------------------------------------------------------
// tb_pulse_generator
//   Directed bench. Three instances share the stimulus: dut0 (RETRIG=0),
//   dut1 (RETRIG=1) and dut2 (4-bit counters, used for the all-ones width
//   case). Inputs change 1 ns after a rising edge and outputs are sampled
//   there as well; "k" is the number of edges since the trigger edge T.
// -----------------------------------------------------------------------------
module tb_pulse_generator;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iClear;
  logic        iTrigger;
  logic        pos_neg;
  logic [15:0] iDelay;
  logic [15:0] iWidth;

  logic p0, b0, d0, o0;
  logic p1, b1, d1, o1;
  logic p2, b2, d2, o2;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  always #5 iClk = ~iClk;

  pulse_generator #(.DLY_W(16), .PW_W(16), .RETRIG(1'b0)) dut0 (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear), .iTrigger(iTrigger),
    .pos_neg(pos_neg), .iDelay(iDelay), .iWidth(iWidth),
    .oPulse(p0), .oBusy(b0), .oDone(d0), .oOverrun(o0)
  );

  pulse_generator #(.DLY_W(16), .PW_W(16), .RETRIG(1'b1)) dut1 (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear), .iTrigger(iTrigger),
    .pos_neg(pos_neg), .iDelay(iDelay), .iWidth(iWidth),
    .oPulse(p1), .oBusy(b1), .oDone(d1), .oOverrun(o1)
  );

  pulse_generator #(.DLY_W(4), .PW_W(4), .RETRIG(1'b0)) dut2 (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear), .iTrigger(iTrigger),
    .pos_neg(pos_neg), .iDelay(iDelay[3:0]), .iWidth(iWidth[3:0]),
    .oPulse(p2), .oBusy(b2), .oDone(d2), .oOverrun(o2)
  );

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Trigger sampled on the next edge (edge T); returns 1 ns after T.
  task automatic fire(input logic p, input logic [15:0] d, input logic [15:0] w);
    pos_neg  = p;
    iDelay   = d;
    iWidth   = w;
    iTrigger = 1'b1;
    step(1);
    iTrigger = 1'b0;
  endtask

  task automatic do_clear();
    iClear = 1'b1;
    step(1);
    iClear = 1'b0;
    step(1);
  endtask

  initial begin
    iRst_n   = 1'b0;
    iClear   = 1'b0;
    iTrigger = 1'b0;
    pos_neg  = 1'b1;
    iDelay   = '0;
    iWidth   = '0;

    // Reset state, active-high polarity: idle low, nothing busy.
    step(2);
    check("rst_pulse", 0, p0, 1'b0);
    check("rst_busy", 0, b0, 1'b0);
    check("rst_done", 0, d0, 1'b0);
    check("rst_ovr", 0, o0, 1'b0);
    iRst_n = 1'b1;
    step(2);

    // 1: D=3, W=5 -> high on T+4..T+8, oDone at T+9; busy T+1..T+8.
    fire(1'b1, 16'd3, 16'd5);
    check("t1_busy", 0, b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check("t1_pulse", k, p0, (k >= 4 && k <= 8));
      check("t1_busy", k, b0, (k >= 1 && k <= 8));
      check("t1_done", k, d0, (k == 9));
    end

    // 2: idle level follows pos_neg with one cycle of lag.
    pos_neg = 1'b0;
    #1;
    check("t2_lag", 0, p0, 1'b0);
    step(1);
    check("t2_idle_hi", 0, p0, 1'b1);
    // D=0, W=0 active-low: low for exactly one cycle at T+1, oDone at T+2.
    // pos_neg flips while the pulse is being produced; latched polarity wins.
    fire(1'b0, 16'd0, 16'd0);
    pos_neg = 1'b1;
    step(1);
    check("t2_pulse", 1, p0, 1'b0);
    check("t2_done", 1, d0, 1'b0);
    pos_neg = 1'b0;
    step(1);
    check("t2_pulse", 2, p0, 1'b1);
    check("t2_done", 2, d0, 1'b1);
    step(1);
    check("t2_pulse", 3, p0, 1'b1);
    check("t2_done", 3, d0, 1'b0);

    // 3/4: D=0, W=10, second trigger (W=10) sampled at T+4.
    //   dut0 drops it: oOverrun at T+5, pulse T+1..T+10, oDone at T+11.
    //   dut1 extends:  pulse T+1..T+14 continuous, single oDone at T+15.
    pos_neg = 1'b1;
    step(2);
    done_cnt = 0;
    fire(1'b1, 16'd0, 16'd10);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("t3_pulse", k, p0, (k >= 1 && k <= 10));
      check("t3_ovr", k, o0, (k == 5));
      check("t3_done", k, d0, (k == 11));
      check("t4_pulse", k, p1, (k >= 1 && k <= 14));
      check("t4_ovr", k, o1, 1'b0);
      if (d1) done_cnt++;
      if (k == 2) pos_neg = 1'b0;
      if (k == 6) pos_neg = 1'b1;
      if (k == 3) begin
        iWidth   = 16'd10;
        iTrigger = 1'b1;
      end
      if (k == 4) iTrigger = 1'b0;
    end
    check("t4_done_at15", 0, (done_cnt == 1), 1'b1);

    // 5: D=2, W=20; clear and trigger together sampled at T+6.
    //   Pulse T+3..T+5, then idle and not busy from T+6, no oDone, trigger ignored.
    do_clear();
    fire(1'b1, 16'd2, 16'd20);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (k <= 5) begin
        check("t5_pulse", k, p0, (k >= 3));
        check("t5_busy", k, b0, 1'b1);
      end else begin
        check("t5_clr_pulse", k, p0, 1'b0);
        check("t5_clr_busy", k, b0, 1'b0);
        check("t5_clr_pulse1", k, p1, 1'b0);
      end
      check("t5_done", k, d0, 1'b0);
      iClear   = (k == 5);
      iTrigger = (k == 5);
    end

    // 6: D=1, W=2 -> pulse T+2..T+3, oDone T+4. A new trigger (D=0, W=3)
    //   held during the oDone cycle is sampled at T+5 -> pulse T+6..T+8,
    //   oDone T+9, with the output idle at T+4 and T+5.
    do_clear();
    fire(1'b1, 16'd1, 16'd2);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check("t6_pulse", k, p0, (k == 2 || k == 3 || (k >= 6 && k <= 8)));
      check("t6_done", k, d0, (k == 4 || k == 9));
      if (k == 4) begin
        iDelay   = 16'd0;
        iWidth   = 16'd3;
        iTrigger = 1'b1;
      end
      if (k == 5) iTrigger = 1'b0;
    end

    // 7: all-ones loads. dut2 (4-bit) D=15, W=15 -> pulse T+16..T+30,
    //   oDone T+31. dut0 D=65535 -> still delaying at T+65535, asserts at T+65536.
    do_clear();
    fire(1'b1, 16'hFFFF, 16'hFFFF);
    for (int k = 1; k <= 32; k++) begin
      step(1);
      check("t7_pulse2", k, p2, (k >= 16 && k <= 30));
      check("t7_done2", k, d2, (k == 31));
      check("t7_dly0", k, p0, 1'b0);
    end
    step(65535 - 32);
    check("t7_pulse0_pre", 65535, p0, 1'b0);
    check("t7_busy0_pre", 65535, b0, 1'b1);
    step(1);
    check("t7_pulse0", 65536, p0, 1'b1);
    check("t7_busy0", 65536, b0, 1'b1);
    do_clear();
    check("t7_clr_pulse", 0, p0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
